max_pool_2x2: RTL

- Consumer end of the pooling-window stream: takes each 4-element fixed-point window on i_pool_data/i_pool_data_valid and produces one max-pooled value per 2x2 region.
- Sits between the pooling line-buffer controller and the next layer's input buffer.
- Applies stride-2 decimation in both dimensions using column and row counters.
- Pipelines the signed compare tree and flags end of frame.

---
 rtl/max_pool_2x2.sv | 102 ++++++++++
 1 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 max-pool over a stream of 4-element windows: stride-2 decimation by
// column/row counters, a two-stage signed compare tree and end-of-frame flagging.
module max_pool_2x2 #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int LINE_WIDTH       = 512,
    parameter int NUM_LINES        = 512,
    parameter int RELU_EN          = 0
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [4*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]    i_pool_data,
    input  logic                                            i_pool_data_valid,
    output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]        o_pooled_data,
    output logic                                            o_pooled_valid,
    output logic                                            o_frame_done,
    output logic [15:0]                                     o_pool_count
);
    localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          col_last, row_last, keep, frame_end;

    logic signed [W-1:0] e0, e1, e2, e3;
    logic signed [W-1:0] m01, m23, pooled;

    // Stage valid and done bits; index 1 is stage 1, index 2 drives the outputs.
    logic [2:1] vld_pipe;
    logic [2:1] done_pipe;

    assign e0 = $signed(i_pool_data[W*0 +: W]);
    assign e1 = $signed(i_pool_data[W*1 +: W]);
    assign e2 = $signed(i_pool_data[W*2 +: W]);
    assign e3 = $signed(i_pool_data[W*3 +: W]);

    assign col_last = (col_cnt == CW'(LINE_WIDTH - 1));
    assign row_last = (row_cnt == RW'(NUM_LINES - 1));

    // Odd trailing column/row has no partner, so it is never kept.
    assign keep = i_pool_data_valid && !col_cnt[0] && !row_cnt[0] &&
                  (int'(col_cnt) <= LINE_WIDTH - 2) && (int'(row_cnt) <= NUM_LINES - 2);
    assign frame_end = i_pool_data_valid && col_last && row_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (i_pool_data_valid) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m01       <= '0;
            m23       <= '0;
            vld_pipe  <= '0;
            done_pipe <= '0;
        end else begin
            if (keep) begin
                m01 <= smax(e0, e1);
                m23 <= smax(e2, e3);
            end
            vld_pipe  <= {vld_pipe[1], keep};
            done_pipe <= {done_pipe[1], frame_end};
        end
    end

    assign pooled = smax(m01, m23);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pooled_data <= '0;
            o_pool_count  <= '0;
        end else begin
            if (vld_pipe[1])
                o_pooled_data <= (RELU_EN != 0 && pooled < 0) ? '0 : pooled;
            // Frame end wins over a coincident output so the next frame starts from zero.
            if (done_pipe[1])
                o_pool_count <= '0;
            else if (vld_pipe[1])
                o_pool_count <= o_pool_count + 16'd1;
        end
    end

    assign o_pooled_valid = vld_pipe[2];
    assign o_frame_done   = done_pipe[2];

endmodule
